// File: rtl/mem_fabric.sv
// Memory-bus interconnect between the picorv32 native port and NUM_SLAVES channels.
// One registered IDLE/BUSY/ACK FSM; per-channel fixed-latency or handshake completion, timeout and unmapped errors.
module mem_fabric #(
    parameter int unsigned             NUM_SLAVES = 8,
    parameter int unsigned             SEL_LSB    = 12,
    parameter int unsigned             SEL_W      = 4,
    parameter logic [4*NUM_SLAVES-1:0] LATENCY    = {NUM_SLAVES{4'd1}},
    parameter int unsigned             TIMEOUT    = 255,
    parameter logic [31:0]             ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_valid,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    input  logic [3:0]               cpu_wstrb,
    output logic                     cpu_ready,
    output logic [31:0]              cpu_rdata,
    output logic [NUM_SLAVES-1:0]    slv_sel,
    output logic                     slv_start,
    output logic [31:0]              slv_addr,
    output logic [31:0]              slv_wdata,
    output logic [3:0]               slv_wstrb,
    input  logic [NUM_SLAVES*32-1:0] slv_rdata,
    input  logic [NUM_SLAVES-1:0]    slv_ready,
    output logic                     err,
    output logic [31:0]              err_addr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cpu_ready_q, cpu_ready_d;
    logic [31:0]             cpu_rdata_q, cpu_rdata_d;
    logic [NUM_SLAVES-1:0]   slv_sel_q, slv_sel_d;
    logic                    slv_start_q, slv_start_d;
    logic [31:0]             slv_addr_q, slv_addr_d;
    logic [31:0]             slv_wdata_q, slv_wdata_d;
    logic [3:0]              slv_wstrb_q, slv_wstrb_d;
    logic                    err_q, err_d;
    logic [31:0]             err_addr_q, err_addr_d;

    logic [SEL_W-1:0]        req_idx_c;
    logic                    mapped_c;
    logic [NUM_SLAVES-1:0]   req_oh_c;
    logic [31:0]             sel_rdata_c;
    logic [3:0]              sel_lat_c;
    logic                    sel_rdy_c;
    logic                    done_c;
    logic                    tout_c;

    assign req_idx_c = cpu_addr[SEL_LSB +: SEL_W];
    assign mapped_c  = 32'(req_idx_c) < NUM_SLAVES;

    // Decode the incoming request and mux the active channel's response.
    always_comb begin
        req_oh_c    = '0;
        sel_rdata_c = '0;
        sel_lat_c   = '0;
        sel_rdy_c   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            req_oh_c[i] = (req_idx_c == SEL_W'(i));
            if (idx_q == SEL_W'(i)) begin
                sel_rdata_c = slv_rdata[32*i +: 32];
                sel_lat_c   = LATENCY[4*i +: 4];
                sel_rdy_c   = slv_ready[i];
            end
        end
    end

    assign done_c = (sel_lat_c == 4'd0) ? sel_rdy_c : (cnt_q == CNT_W'(sel_lat_c));
    assign tout_c = (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            slv_sel_q   <= '0;
            slv_start_q <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            slv_wstrb_q <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            slv_sel_q   <= slv_sel_d;
            slv_start_q <= slv_start_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            slv_wstrb_q <= slv_wstrb_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cpu_valid) state_d = mapped_c ? S_BUSY : S_ACK;
            S_BUSY:  if (done_c || tout_c) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; a normal completion wins over timeout.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        slv_sel_d   = slv_sel_q;
        slv_start_d = 1'b0;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        slv_wstrb_d = slv_wstrb_q;
        err_d       = 1'b0;
        err_addr_d  = err_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_valid) begin
                    slv_addr_d  = cpu_addr;
                    slv_wdata_d = cpu_wdata;
                    slv_wstrb_d = cpu_wstrb;
                    idx_d       = req_idx_c;
                    if (mapped_c) begin
                        slv_sel_d   = req_oh_c;
                        slv_start_d = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else begin
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = ERR_DATA;
                        err_d       = 1'b1;
                        err_addr_d  = cpu_addr;
                    end
                end
            end
            S_BUSY: begin
                if (done_c) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = sel_rdata_c;
                    slv_sel_d   = '0;
                end else if (tout_c) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = ERR_DATA;
                    err_d       = 1'b1;
                    err_addr_d  = slv_addr_q;
                    slv_sel_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign slv_sel   = slv_sel_q;
    assign slv_start = slv_start_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;
    assign slv_wstrb = slv_wstrb_q;
    assign err       = err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_fabric.sv
// Scoreboard bench for mem_fabric: 6 channels (fixed L=1,2,3,15 and two handshake), TIMEOUT=16.
// A driver pushes expected completions derived from the timing rules; a negedge monitor pops and compares.
module tb_mem_fabric;

    localparam int          NS  = 6;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct {
        int unsigned  cyc;
        logic [31:0]  rdata;
        logic         err;
        logic [31:0]  err_addr;
        logic [5:0]   sel;
        int unsigned  starts;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   wstrb;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           cpu_valid;
    logic [31:0]    cpu_addr;
    logic [31:0]    cpu_wdata;
    logic [3:0]     cpu_wstrb;
    logic           cpu_ready;
    logic [31:0]    cpu_rdata;
    logic [NS-1:0]  slv_sel;
    logic           slv_start;
    logic [31:0]    slv_addr;
    logic [31:0]    slv_wdata;
    logic [3:0]     slv_wstrb;
    logic [NS*32-1:0] slv_rdata;
    logic [NS-1:0]  slv_ready;
    logic           err;
    logic [31:0]    err_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    exp_t        q[$];
    exp_t        me;
    int          mon_starts = 0;
    logic [31:0] rdata_hold = '0;
    logic [31:0] model_err_addr = '0;
    logic [31:0] ch_data [NS];
    int          lat_tab [NS] = '{1, 2, 3, 15, 0, 0};

    mem_fabric #(
        .NUM_SLAVES (NS),
        .SEL_LSB    (12),
        .SEL_W      (4),
        .LATENCY    (24'h00F321),
        .TIMEOUT    (16),
        .ERR_DATA   (ERR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .slv_sel   (slv_sel),
        .slv_start (slv_start),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_wstrb (slv_wstrb),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready),
        .err       (err),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every slave strobe and every completion against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (slv_start) begin
                mon_starts++;
                if (q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL start_unexpected: slv_start with no request, slv_sel %h", slv_sel);
                end else begin
                    check("start_sel",   32'(slv_sel),   32'(q[0].sel));
                    check("start_addr",  slv_addr,       q[0].addr);
                    check("start_wdata", slv_wdata,      q[0].wdata);
                    check("start_wstrb", 32'(slv_wstrb), 32'(q[0].wstrb));
                end
            end
            if (cpu_ready) begin
                check("ack_sel",   32'(slv_sel),   32'h0);
                check("ack_start", 32'(slv_start), 32'h0);
                if (q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL ready_unexpected: cpu_ready with no request, rdata %h", cpu_rdata);
                end else begin
                    me = q.pop_front();
                    check("ready_cycle", 32'(cyc),        32'(me.cyc));
                    check("rdata",       cpu_rdata,       me.rdata);
                    check("err",         32'(err),        32'(me.err));
                    check("err_addr",    err_addr,        me.err_addr);
                    check("start_count", 32'(mon_starts), 32'(me.starts));
                    rdata_hold = me.rdata;
                end
                mon_starts = 0;
            end else begin
                check("err_idle",   32'(err), 32'h0);
                check("rdata_hold", cpu_rdata, rdata_hold);
                if (slv_sel != '0)
                    check("busy_sel", 32'(slv_sel), (q.size() > 0) ? 32'(q[0].sel) : 32'h0);
            end
        end
    end

    task automatic load_rdata();
        for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = ch_data[i];
    endtask

    // Issue one request in the current cycle (cycle 0); k = cycle the handshake slave raises ready (0 = never).
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          input int k, input bit drop);
        exp_t e;
        int   idx;
        int   lat;
        int   n;
        bit   hs;
        bit   got;
        idx = int'(addr[15:12]);
        hs  = (idx < NS) && (lat_tab[idx] == 0);
        load_rdata();
        e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
        e.err = 1'b0; e.sel = '0; e.starts = 0;
        if (idx >= NS) begin
            lat = 1; e.err = 1'b1; e.rdata = ERR; model_err_addr = addr;
        end else begin
            e.sel = 6'(1 << idx);
            e.starts = 1;
            if (lat_tab[idx] != 0) begin
                lat = lat_tab[idx] + 1; e.rdata = ch_data[idx];
            end else if (k >= 1 && k <= 16) begin
                lat = k + 1; e.rdata = ch_data[idx];
            end else begin
                lat = 17; e.err = 1'b1; e.rdata = ERR; model_err_addr = addr;
            end
        end
        e.err_addr = model_err_addr;
        e.cyc = cyc + 32'(lat);
        q.push_back(e);
        cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
        slv_ready = NS'($urandom);
        if (hs) slv_ready[idx] = 1'b0;
        got = 1'b0;
        for (n = 1; n <= 40 && !got; n++) begin
            @(posedge clk); #1;
            slv_ready = NS'($urandom);
            if (hs) slv_ready[idx] = (n == k);
            if (drop) begin
                cpu_valid = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
            end
            got = cpu_ready;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL txn_hang: no cpu_ready for addr %h within 40 cycles", addr);
            q.delete();
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        slv_ready = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'h0);
        check({tag, "_cpu_rdata"}, cpu_rdata,      32'h0);
        check({tag, "_slv_sel"},   32'(slv_sel),   32'h0);
        check({tag, "_slv_start"}, 32'(slv_start), 32'h0);
        check({tag, "_slv_addr"},  slv_addr,       32'h0);
        check({tag, "_slv_wdata"}, slv_wdata,      32'h0);
        check({tag, "_slv_wstrb"}, 32'(slv_wstrb), 32'h0);
        check({tag, "_err"},       32'(err),       32'h0);
        check({tag, "_err_addr"},  err_addr,       32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [31:0] a;
        int          idx;
        rst = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        slv_ready = '0;
        for (int i = 0; i < NS; i++) ch_data[i] = $urandom;
        load_rdata();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        ch_data[0] = 32'h1234_5678;
        do_txn(32'h0000_0010, 4'h0, 32'h0, 0, 1'b0);
        do_txn(32'h0000_2004, 4'hF, 32'h0000_00A5, 0, 1'b0);
        ch_data[4] = 32'h0000_0041;
        do_txn(32'h0000_4000, 4'h0, 32'h0, 5, 1'b0);
        do_txn(32'h0000_4000, 4'h0, 32'h0, 0, 1'b0);
        do_txn(32'h0000_7000, 4'h0, 32'h0, 0, 1'b0);
        do_txn(32'h0000_F123, 4'h3, 32'h0, 0, 1'b0);

        // Reset during cycle 2 of an L=3 access aborts it with no completion.
        load_rdata();
        e.addr = 32'h0000_2008; e.wdata = 32'h0; e.wstrb = 4'h0; e.sel = 6'b000100;
        e.starts = 1; e.rdata = ch_data[2]; e.err = 1'b0; e.err_addr = model_err_addr; e.cyc = cyc + 4;
        q.push_back(e);
        cpu_valid = 1'b1; cpu_addr = 32'h0000_2008; cpu_wdata = '0; cpu_wstrb = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        q.delete();
        mon_starts = 0;
        rdata_hold = '0;
        model_err_addr = '0;
        cpu_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ch_data[2] = 32'hCAFE_0002;
        do_txn(32'h0000_2008, 4'h0, 32'h0, 0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < NS; i++) ch_data[i] = $urandom;
            a   = $urandom;
            idx = $urandom_range(0, 7);
            a[15:12] = 4'(idx);
            do_txn(a, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), $urandom,
                   $urandom_range(1, 20), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_fabric.md
# mem_fabric

Parametrised memory-bus interconnect between the picorv32 native memory port and up to NUM_SLAVES peripheral/memory channels. It replaces hand-written chip-select, ready and read-mux logic with one registered FSM. Each channel is either fixed-latency (1-15 cycles) or handshake (waits for the slave's ready). The block adds a bus timeout, an unmapped-address error response and faulting-address capture.

## Interface
- NUM_SLAVES, 8: channel count, 1..2**SEL_W.
- SEL_LSB, 12: lowest cpu_addr bit of the channel-select field.
- SEL_W, 4: width of the select field; channel index = cpu_addr[SEL_LSB+SEL_W-1:SEL_LSB].
- LATENCY, {NUM_SLAVES{4'd1}}: packed 4 bits per channel, channel i at [4i+3:4i]. 0 = handshake mode; 1-15 = fixed cycles.
- TIMEOUT, 255: maximum BUSY cycles before an error completion, 16..65535.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on error completions.

Ports:
- clk  in  1  system clock. One clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_valid  in  1  picorv32 mem_valid.
- cpu_addr  in  32  picorv32 mem_addr.
- cpu_wdata  in  32  picorv32 mem_wdata.
- cpu_wstrb  in  4  picorv32 mem_wstrb; 0 = read.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data; valid while cpu_ready=1.
- slv_sel  out  NUM_SLAVES  one-hot select, high for the whole BUSY phase.
- slv_start  out  1  one-cycle strobe on the first BUSY cycle. Slaves with side effects, such as FIFO push/pop, qualify on it.
- slv_addr  out  32  latched cpu_addr.
- slv_wdata  out  32  latched cpu_wdata.
- slv_wstrb  out  4  latched cpu_wstrb.
- slv_rdata  in  NUM_SLAVES*32  channel i at [32i+31:32i].
- slv_ready  in  NUM_SLAVES  per-channel ready; used only in handshake mode.
- err  out  1  one-cycle pulse coincident with an error completion.
- err_addr  out  32  address of the most recent error, held until the next error or reset.

## Operation
- States: IDLE, BUSY, ACK.
- Reset: state=IDLE. cpu_ready, cpu_rdata, slv_sel, slv_start, slv_addr, slv_wdata, slv_wstrb, err and err_addr all 0. Reset mid-transaction aborts immediately; the slave sees slv_sel drop with no completion.
- IDLE, cpu_valid=1:
  - Latch addr/wdata/wstrb into the slv_* outputs and latch index idx.
  - idx < NUM_SLAVES: go to BUSY, cnt=1.
  - Otherwise (unmapped): go to ACK with cpu_rdata=ERR_DATA, err=1, err_addr=cpu_addr.
- BUSY: slv_sel[idx]=1; slv_start=1 only when cnt==1. Completion conditions:
  - Fixed mode (L=LATENCY[idx]): complete when cnt==L. Capture slv_rdata[idx] into cpu_rdata.
  - Handshake mode: complete in the first cycle with slv_ready[idx]=1. Capture slv_rdata[idx].
  - Timeout: if neither condition holds and cnt==TIMEOUT, complete with cpu_rdata=ERR_DATA, err=1, err_addr=slv_addr.
  - Normal completion takes priority over timeout in the same cycle.
  - Otherwise cnt increments.
- ACK: cpu_ready=1 for exactly one cycle; slv_sel=0, slv_start=0. Next state is always IDLE. cpu_valid seen during ACK is ignored, because picorv32 holds valid through the ready cycle.
- cpu_rdata holds its value after ACK until the next completion.
- Writes return cpu_rdata = captured slv_rdata; picorv32 ignores it.
- cpu_valid dropping during BUSY is ignored; the transaction completes normally.
- Read/write qualification (e.g. UART re = sel & start & wstrb==0) is the slave's job; the fabric does not gate by direction.
- Counter width is $clog2(TIMEOUT+1). No wrap occurs, because TIMEOUT bounds cnt.

## Timing
- Request accepted in cycle 0 (IDLE, cpu_valid=1).
- Fixed latency L: BUSY in cycles 1..L; cpu_ready in cycle L+1. The slave has L cycles from slv_sel to drive slv_rdata; a registered BRAM needs L>=1.
- Handshake: slv_ready first seen in cycle k (k>=1) gives cpu_ready in cycle k+1.
- Timeout: cpu_ready and err in cycle TIMEOUT+1.
- Unmapped: cpu_ready and err in cycle 1.
- Back-to-back throughput: the next transaction is accepted at the earliest in cycle L+2.
- All outputs are registered; there is no combinational path from cpu_* or slv_* inputs to any output.

## Test plan
- Fixed read: channel 0, L=1, slv_rdata0=32'h1234_5678, read addr 0x0000_0010 -> slv_sel=8'h01 in cycle 1, slv_start pulse in cycle 1, cpu_ready and rdata=32'h1234_5678 in cycle 2, err=0.
- Fixed write: channel 2, L=3, write 0x2004 with wstrb=4'hF and wdata=32'hA5 -> slv_sel=8'h04 in cycles 1-3, slv_start only in cycle 1, slv_wstrb=4'hF, cpu_ready in cycle 4. With cpu_valid held through ACK there is no second slv_start.
- Handshake: channel 4, LATENCY=0, slv_ready4 raised in cycle 5 with rdata=32'h0000_0041 -> cpu_ready in cycle 6, rdata=32'h41.
- Timeout: TIMEOUT=16, handshake channel never ready, read addr 0x4000 -> cpu_ready and err in cycle 17, rdata=32'hDEAD_BEEF, err_addr=32'h0000_4000.
- Unmapped: NUM_SLAVES=6, read 0x7000 -> cpu_ready and err in cycle 1, slv_sel never asserted, err_addr=32'h0000_7000.
- Reset: rst asserted in cycle 2 of an L=3 access -> next cycle all outputs 0, state IDLE, no cpu_ready. A new request after rst deasserts completes normally.
